// File: rtl/pc_sequencer.sv
// Command sequencer driving a downstream program counter with increment/load pulses.
// Optional 4-entry return stack for CALL/RET is compiled only with PC_SEQ_STACK_EN.
module pc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_arg,
  input  logic [7:0] pc_cur,
  output logic       pc_en,
  output logic       pc_load,
  output logic [7:0] pc_target,
  output logic       halted,
  output logic       stack_err,
  output logic [2:0] stack_depth
);

  typedef enum logic [2:0] {
    OP_STEP   = 3'b000,
    OP_JUMP   = 3'b001,
    OP_CALL   = 3'b010,
    OP_RET    = 3'b011,
    OP_LSET   = 3'b100,
    OP_LBR    = 3'b101,
    OP_HALT   = 3'b110,
    OP_CLRERR = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e     state;
  logic [7:0] loop_cnt;

`ifdef PC_SEQ_STACK_EN
  logic [7:0] stack [4];
  logic [2:0] depth;
  logic       err;

  assign stack_depth = depth;
  assign stack_err   = err;
`else
  // Without the stack the current PC is never needed.
  logic unused_pc_cur;
  assign unused_pc_cur = ^pc_cur;
  assign stack_depth   = 3'd0;
  assign stack_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      pc_en     <= 1'b0;
      pc_load   <= 1'b0;
      pc_target <= 8'h00;
      halted    <= 1'b0;
      loop_cnt  <= 8'h00;
`ifdef PC_SEQ_STACK_EN
      depth     <= 3'd0;
      err       <= 1'b0;
      for (int i = 0; i < 4; i++) stack[i] <= 8'h00;
`endif
    end else begin
      // Pulses live for exactly the ISSUE cycle.
      pc_en   <= 1'b0;
      pc_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            state     <= S_ISSUE;
            cmd_ready <= 1'b0;
            case (op_e'(cmd_op))
              OP_STEP: pc_en <= 1'b1;
              OP_JUMP: begin
                pc_load   <= 1'b1;
                pc_target <= cmd_arg;
              end
              OP_CALL: begin
`ifdef PC_SEQ_STACK_EN
                if (depth == 3'd4) begin
                  err   <= 1'b1;
                  pc_en <= 1'b1;
                end else begin
                  stack[depth[1:0]] <= pc_cur + 8'd1;
                  depth             <= depth + 3'd1;
                  pc_load           <= 1'b1;
                  pc_target         <= cmd_arg;
                end
`else
                pc_load   <= 1'b1;
                pc_target <= cmd_arg;
`endif
              end
              OP_RET: begin
`ifdef PC_SEQ_STACK_EN
                if (depth == 3'd0) begin
                  err   <= 1'b1;
                  pc_en <= 1'b1;
                end else begin
                  // depth 4 wraps the low bits to 0, so minus one lands on entry 3.
                  pc_target <= stack[depth[1:0] - 2'd1];
                  depth     <= depth - 3'd1;
                  pc_load   <= 1'b1;
                end
`else
                pc_en <= 1'b1;
`endif
              end
              OP_LSET: loop_cnt <= cmd_arg;
              OP_LBR: begin
                if (loop_cnt != 8'h00) begin
                  loop_cnt  <= loop_cnt - 8'd1;
                  pc_load   <= 1'b1;
                  pc_target <= cmd_arg;
                end else begin
                  pc_en <= 1'b1;
                end
              end
              OP_HALT: begin
                state  <= S_HALT;
                halted <= 1'b1;
              end
              OP_CLRERR: begin
`ifdef PC_SEQ_STACK_EN
                err <= 1'b0;
`endif
              end
              default: ;
            endcase
          end
        end
        S_ISSUE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        S_HALT: ;
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expectations follow PC_SEQ_STACK_EN.
module tb_pc_sequencer;

`ifdef PC_SEQ_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  localparam logic [2:0] OP_STEP = 3'b000, OP_JUMP = 3'b001, OP_CALL = 3'b010,
                         OP_RET = 3'b011, OP_LSET = 3'b100, OP_LBR = 3'b101,
                         OP_HALT = 3'b110, OP_CLRERR = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic [7:0] cmd_arg = 8'h00;
  logic [7:0] pc_cur = 8'h00;
  logic       pc_en, pc_load, halted, stack_err;
  logic [7:0] pc_target;
  logic [2:0] stack_depth;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc_cur(pc_cur), .pc_en(pc_en),
    .pc_load(pc_load), .pc_target(pc_target), .halted(halted),
    .stack_err(stack_err), .stack_depth(stack_depth)
  );

  // Present a command, let it be accepted, and return 1ns into the ISSUE cycle.
  task automatic issue(input logic [2:0] op, input logic [7:0] arg);
    cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Advance from ISSUE back to IDLE.
  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b exp 1", cmd_ready); end
    tests++; if (pc_en !== 1'b0) begin fails++; $display("FAIL rst_en: got %b exp 0", pc_en); end
    tests++; if (pc_load !== 1'b0) begin fails++; $display("FAIL rst_load: got %b exp 0", pc_load); end
    tests++; if (pc_target !== 8'h00) begin fails++; $display("FAIL rst_target: got %h exp 00", pc_target); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rst_halted: got %b exp 0", halted); end
    tests++; if (stack_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b exp 0", stack_err); end
    tests++; if (stack_depth !== 3'd0) begin fails++; $display("FAIL rst_depth: got %0d exp 0", stack_depth); end
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_step();
    issue(OP_STEP, 8'hAA);
    tests++; if (pc_en !== 1'b1) begin fails++; $display("FAIL step_en: got %b exp 1", pc_en); end
    tests++; if (pc_load !== 1'b0) begin fails++; $display("FAIL step_load: got %b exp 0", pc_load); end
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL step_ready_issue: got %b exp 0", cmd_ready); end
    settle();
    tests++; if (pc_en !== 1'b0) begin fails++; $display("FAIL step_en_drop: got %b exp 0", pc_en); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL step_ready_idle: got %b exp 1", cmd_ready); end
  endtask

  task automatic test_jump();
    issue(OP_JUMP, 8'h5A);
    tests++; if (pc_load !== 1'b1) begin fails++; $display("FAIL jump_load: got %b exp 1", pc_load); end
    tests++; if (pc_en !== 1'b0) begin fails++; $display("FAIL jump_en: got %b exp 0", pc_en); end
    tests++; if (pc_target !== 8'h5A) begin fails++; $display("FAIL jump_target: got %h exp 5a", pc_target); end
    settle();
    tests++; if (pc_load !== 1'b0) begin fails++; $display("FAIL jump_load_drop: got %b exp 0", pc_load); end
    tests++; if (pc_target !== 8'h5A) begin fails++; $display("FAIL jump_target_hold: got %h exp 5a", pc_target); end
  endtask

  task automatic test_call_ret();
    pc_cur = 8'h10;
    issue(OP_CALL, 8'h40);
    pc_cur = 8'h99;  // must not affect the pushed value
    tests++; if (pc_load !== 1'b1) begin fails++; $display("FAIL call_load: got %b exp 1", pc_load); end
    tests++; if (pc_target !== 8'h40) begin fails++; $display("FAIL call_target: got %h exp 40", pc_target); end
    tests++; if (stack_depth !== (STK ? 3'd1 : 3'd0)) begin fails++; $display("FAIL call_depth: got %0d exp %0d", stack_depth, STK ? 1 : 0); end
    settle();
    issue(OP_RET, 8'h00);
    tests++; if (pc_load !== STK) begin fails++; $display("FAIL ret_load: got %b exp %b", pc_load, STK); end
    tests++; if (pc_en !== !STK) begin fails++; $display("FAIL ret_en: got %b exp %b", pc_en, !STK); end
    tests++; if (pc_target !== (STK ? 8'h11 : 8'h40)) begin fails++; $display("FAIL ret_target: got %h exp %h", pc_target, STK ? 8'h11 : 8'h40); end
    tests++; if (stack_depth !== 3'd0) begin fails++; $display("FAIL ret_depth: got %0d exp 0", stack_depth); end
    settle();
  endtask

  task automatic test_stack_limits();
    pc_cur = 8'hFF;
    issue(OP_CALL, 8'h00);
    tests++; if (pc_target !== 8'h00) begin fails++; $display("FAIL wrap_call_target: got %h exp 00", pc_target); end
    settle();
    issue(OP_RET, 8'h00);
    tests++; if (pc_load !== STK) begin fails++; $display("FAIL wrap_ret_load: got %b exp %b", pc_load, STK); end
    tests++; if (pc_target !== 8'h00) begin fails++; $display("FAIL wrap_ret_target: got %h exp 00", pc_target); end
    settle();
    pc_cur = 8'h20;
    for (int i = 0; i < 4; i++) begin
      issue(OP_CALL, 8'h30 + 8'(i));
      tests++; if (pc_load !== 1'b1 || pc_target !== 8'h30 + 8'(i)) begin fails++; $display("FAIL fill_call%0d: got load %b tgt %h exp load 1 tgt %h", i, pc_load, pc_target, 8'h30 + 8'(i)); end
      tests++; if (stack_depth !== (STK ? 3'(i + 1) : 3'd0)) begin fails++; $display("FAIL fill_depth%0d: got %0d exp %0d", i, stack_depth, STK ? i + 1 : 0); end
      settle();
    end
    issue(OP_CALL, 8'h34);
    tests++; if (pc_en !== STK || pc_load !== !STK) begin fails++; $display("FAIL ovf_pulse: got en %b load %b exp en %b load %b", pc_en, pc_load, STK, !STK); end
    tests++; if (pc_target !== (STK ? 8'h33 : 8'h34)) begin fails++; $display("FAIL ovf_target: got %h exp %h", pc_target, STK ? 8'h33 : 8'h34); end
    tests++; if (stack_depth !== (STK ? 3'd4 : 3'd0)) begin fails++; $display("FAIL ovf_depth: got %0d exp %0d", stack_depth, STK ? 4 : 0); end
    tests++; if (stack_err !== STK) begin fails++; $display("FAIL ovf_err: got %b exp %b", stack_err, STK); end
    settle();
    issue(OP_CLRERR, 8'h00);
    tests++; if (stack_err !== 1'b0 || pc_en !== 1'b0 || pc_load !== 1'b0) begin fails++; $display("FAIL clrerr1: got err %b en %b load %b exp 0 0 0", stack_err, pc_en, pc_load); end
    settle();
    for (int i = 0; i < 4; i++) begin
      issue(OP_RET, 8'h00);
      tests++; if (pc_load !== STK || pc_en !== !STK) begin fails++; $display("FAIL drain_pulse%0d: got en %b load %b exp en %b load %b", i, pc_en, pc_load, !STK, STK); end
      tests++; if (pc_target !== (STK ? 8'h21 : 8'h34)) begin fails++; $display("FAIL drain_target%0d: got %h exp %h", i, pc_target, STK ? 8'h21 : 8'h34); end
      tests++; if (stack_depth !== (STK ? 3'(3 - i) : 3'd0)) begin fails++; $display("FAIL drain_depth%0d: got %0d exp %0d", i, stack_depth, STK ? 3 - i : 0); end
      settle();
    end
    issue(OP_RET, 8'h00);
    tests++; if (pc_en !== 1'b1 || pc_load !== 1'b0) begin fails++; $display("FAIL udf_pulse: got en %b load %b exp en 1 load 0", pc_en, pc_load); end
    tests++; if (stack_err !== STK) begin fails++; $display("FAIL udf_err: got %b exp %b", stack_err, STK); end
    settle();
    issue(OP_CLRERR, 8'h00);
    tests++; if (stack_err !== 1'b0) begin fails++; $display("FAIL clrerr2: got %b exp 0", stack_err); end
    settle();
  endtask

  task automatic test_loop();
    logic [2:0] exp_load;
    exp_load = 3'b011;
    issue(OP_LSET, 8'h02);
    tests++; if (pc_en !== 1'b0 || pc_load !== 1'b0 || cmd_ready !== 1'b0) begin fails++; $display("FAIL lset: got en %b load %b ready %b exp 0 0 0", pc_en, pc_load, cmd_ready); end
    settle();
    // Four LBRs: two loads, then pc_en twice since the count stays at zero.
    for (int i = 0; i < 4; i++) begin
      issue(OP_LBR, 8'h20);
      tests++; if (pc_load !== (i < 2) || pc_en !== (i >= 2)) begin fails++; $display("FAIL lbr%0d: got en %b load %b exp en %b load %b", i, pc_en, pc_load, i >= 2, i < 2); end
      if (i < 2) begin
        tests++; if (pc_target !== 8'h20) begin fails++; $display("FAIL lbr_target%0d: got %h exp 20", i, pc_target); end
      end
      settle();
    end
  endtask

  task automatic test_back_to_back();
    cmd_op = OP_STEP; cmd_arg = 8'h00; cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) cmd_op = OP_JUMP;  // changed while not ready; next accept takes JUMP
      tests++; if (pc_en !== (i == 0) || pc_load !== (i == 2 || i == 4)) begin fails++; $display("FAIL b2b%0d: got en %b load %b exp en %b load %b", i, pc_en, pc_load, i == 0, i == 2 || i == 4); end
      tests++; if (cmd_ready !== (i % 2 == 1)) begin fails++; $display("FAIL b2b_ready%0d: got %b exp %b", i, cmd_ready, i % 2 == 1); end
    end
    cmd_valid = 1'b0;
    settle();
  endtask

  task automatic test_halt_reset();
    issue(OP_HALT, 8'h00);
    tests++; if (halted !== 1'b1 || cmd_ready !== 1'b0 || pc_en !== 1'b0) begin fails++; $display("FAIL halt: got halted %b ready %b en %b exp 1 0 0", halted, cmd_ready, pc_en); end
    cmd_op = OP_STEP; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++; if (pc_en !== 1'b0 || pc_load !== 1'b0 || halted !== 1'b1) begin fails++; $display("FAIL halt_ignore%0d: got en %b load %b halted %b exp 0 0 1", i, pc_en, pc_load, halted); end
    end
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++; if (halted !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL halt_exit: got halted %b ready %b exp 0 1", halted, cmd_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    settle();
    issue(OP_JUMP, 8'h77);
    tests++; if (pc_load !== 1'b1) begin fails++; $display("FAIL abort_pre: got %b exp 1", pc_load); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (pc_load !== 1'b0 || pc_en !== 1'b0 || pc_target !== 8'h00) begin fails++; $display("FAIL abort_now: got load %b en %b tgt %h exp 0 0 00", pc_load, pc_en, pc_target); end
    tests++; if (cmd_ready !== 1'b1 || halted !== 1'b0 || stack_err !== 1'b0 || stack_depth !== 3'd0) begin fails++; $display("FAIL abort_state: got ready %b halted %b err %b depth %0d exp 1 0 0 0", cmd_ready, halted, stack_err, stack_depth); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests++; if (pc_load !== 1'b0 || pc_en !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL post_rst%0d: got load %b en %b ready %b exp 0 0 1", i, pc_load, pc_en, cmd_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_jump();
    test_call_ret();
    test_stack_limits();
    test_loop();
    test_back_to_back();
    test_halt_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port cmd_valid  in  1  command present.
REQ-004 SHALL have port cmd_ready  out  1  sequencer can accept a command.
REQ-005 SHALL have port cmd_op  in  3  opcode: 000 STEP, 001 JUMP, 010 CALL, 011 RET, 100 LSET, 101 LBR, 110 HALT, 111 CLRERR.
REQ-006 SHALL have port cmd_arg  in  8  jump target or loop count.
REQ-007 SHALL have port pc_cur  in  8  current value of the downstream program counter.
REQ-008 SHALL have port pc_en  out  1  one-cycle increment pulse to the counter.
REQ-009 SHALL have port pc_load  out  1  one-cycle load pulse to the counter.
REQ-010 SHALL have port pc_target  out  8  load value, valid while pc_load=1.
REQ-011 SHALL have port halted  out  1  sequencer is stopped.
REQ-012 SHALL have port stack_err  out  1  sticky stack overflow/underflow flag.
REQ-013 SHALL have port stack_depth  out  3  return-stack occupancy, 0..4.

Function
REQ-014 SHALL transfer a command on a rising edge only when cmd_valid=1 and cmd_ready=1.
REQ-015 SHALL use three states: IDLE (cmd_ready=1), ISSUE (cmd_ready=0, one cycle), HALT (cmd_ready=0).
REQ-016 SHALL move IDLE->ISSUE on accept, except HALT, which goes IDLE->HALT. ISSUE->IDLE is unconditional.
REQ-017 SHALL drive pc_en/pc_load as registered pulses during the ISSUE cycle only: latency 1 cycle, throughput 1 command per 2 cycles.
REQ-018 SHALL never assert pc_en and pc_load in the same cycle; pc_target SHALL hold its last value when pc_load=0.
REQ-019 SHALL handle each opcode as follows:
- STEP: pc_en=1.
- JUMP: pc_load=1, pc_target=cmd_arg.
- CALL: push (pc_cur+1) mod 256, then load cmd_arg.
- RET: pop, then load the popped value.
REQ-020 SHALL, for CALL at depth 4: set stack_err, do not push, and issue pc_en instead of a load.
REQ-021 SHALL, for RET at depth 0: set stack_err and issue pc_en.
REQ-022 SHALL implement LSET as: loop_cnt<=cmd_arg, with neither pulse asserted; the ISSUE cycle is still consumed.
REQ-023 SHALL implement LBR as: if loop_cnt!=0, decrement loop_cnt and load cmd_arg; if loop_cnt=0, keep it at 0 and issue pc_en.
REQ-024 SHALL implement CLRERR as: stack_err<=0, with no pulse.
REQ-025 SHALL, in HALT, assert halted=1 and ignore all commands; only rst_n exits HALT.
REQ-026 SHALL sample pc_cur for CALL on the accept edge.
REQ-027 SHALL ignore cmd_op and cmd_arg while cmd_ready=0.

Reset
REQ-028 SHALL, while rst_n=0, force: state IDLE, cmd_ready=1, pc_en=0, pc_load=0, pc_target=0x00, halted=0, stack_err=0, stack_depth=0, loop_cnt=0, and all stack entries 0x00.
REQ-029 SHALL abort an in-progress ISSUE pulse immediately on reset assertion; no pulse is issued after release.

Configuration
REQ-030 SHALL compile the return stack only when macro PC_SEQ_STACK_EN is defined.
REQ-031 SHALL, with PC_SEQ_STACK_EN defined, implement CALL/RET with the 4-entry stack exactly as in REQ-019 to REQ-021.
REQ-032 SHALL, without PC_SEQ_STACK_EN, behave as follows:
- CALL acts as JUMP.
- RET acts as STEP.
- stack_depth is tied to 0.
- stack_err is never set.

Verification
REQ-033 SHALL cover: reset, then STEP accepted -> pc_en=1 for exactly one cycle on the next cycle, cmd_ready=0 that cycle, then 1.
REQ-034 SHALL cover: pc_cur=0x10, CALL 0x40 -> pc_load=1, pc_target=0x40, depth=1; then RET -> pc_target=0x11, depth=0.
REQ-035 SHALL cover: pc_cur=0xFF, CALL 0x00 -> pushed value 0x00 (wrap); five CALLs -> depth stays 4, stack_err=1, fifth issues pc_en; then CLRERR -> stack_err=0.
REQ-036 SHALL cover: LSET 2, then LBR 0x20 three times -> loads, loads, then pc_en; loop_cnt ends at 0.
REQ-037 SHALL cover: HALT -> halted=1, cmd_ready=0, STEP ignored for 10 cycles; assert rst_n mid-ISSUE -> pulse drops at once, all outputs at reset values.
